mdu: RTL

Iterative multiply/divide unit for the 5-stage MIPS pipeline. It sits in the EX stage and executes mult/multu/div/divu/mfhi/mflo/mthi/mtlo against private HI/LO registers. It drives MDUReadyE to the hazard unit, which holds IF/ID/EX (StallF/StallD/StallE) while MDUReadyE is low. It is the responder at the other end of that stall handshake.

---
 rtl/mdu_pkg.sv | 26 ++
 rtl/mdu_divider.sv | 55 +++++
 rtl/mdu.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mdu_pkg : shared MDU opcode and FSM state encodings      rev 1.0
// ---------------------------------------------------------------------------
package mdu_pkg;

    typedef enum logic [3:0] {
        MDU_NOP   = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8
    } mdu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_t;

endpackage
`default_nettype wire

// File: rtl/mdu_divider.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mdu_divider : unsigned restoring divider, one quotient bit per cycle  rev 1.0
// ---------------------------------------------------------------------------
module mdu_divider #(
    parameter int WIDTH      = 32,
    parameter int DIV_CYCLES = WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             last
);

    localparam int CW = $clog2(DIV_CYCLES + 1);

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // Quotient register doubles as the dividend shift source.
    assign shifted = {remainder, quotient[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs};
    assign last    = (count == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient  <= '0;
            remainder <= '0;
            dvs       <= '0;
            count     <= '0;
        end else if (start) begin
            quotient  <= dividend;
            remainder <= '0;
            dvs       <= divisor;
            count     <= CW'(DIV_CYCLES);
        end else if (count != '0) begin
            if (diff[WIDTH]) begin
                remainder <= shifted[WIDTH-1:0];
                quotient  <= {quotient[WIDTH-2:0], 1'b0};
            end else begin
                remainder <= diff[WIDTH-1:0];
                quotient  <= {quotient[WIDTH-2:0], 1'b1};
            end
            count <= count - CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/mdu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mdu : EX-stage multiply/divide unit with private HI/LO and stall handshake
// rev 1.0
// ---------------------------------------------------------------------------
module mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DIV_CYCLES = WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       MDUOpE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    output logic             MDUReadyE,
    output logic [WIDTH-1:0] MDUResultE
);

    mdu_op_t          op;
    mdu_state_t       state;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             q_neg;
    logic             r_neg;

    logic             is_div;
    logic             div_start;
    logic             div_last;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;

    logic             mul_signed;
    logic [2*WIDTH-1:0] mul_a;
    logic [2*WIDTH-1:0] mul_b;
    logic [2*WIDTH-1:0] product;

    assign op        = mdu_op_t'(MDUOpE);
    assign is_div    = (op == MDU_DIV) || (op == MDU_DIVU);
    assign div_start = (state == ST_IDLE) && is_div;

    assign a_neg = (op == MDU_DIV) && SrcAE[WIDTH-1];
    assign b_neg = (op == MDU_DIV) && SrcBE[WIDTH-1];
    assign a_mag = a_neg ? -SrcAE : SrcAE;
    assign b_mag = b_neg ? -SrcBE : SrcBE;

    // One 2W-bit multiplier serves both forms: extension selects signedness.
    assign mul_signed = (op == MDU_MULT);
    assign mul_a      = {{WIDTH{mul_signed & SrcAE[WIDTH-1]}}, SrcAE};
    assign mul_b      = {{WIDTH{mul_signed & SrcBE[WIDTH-1]}}, SrcBE};
    assign product    = mul_a * mul_b;

    mdu_divider #(
        .WIDTH      (WIDTH),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_divider (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (quo),
        .remainder (rem),
        .last      (div_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            hi    <= '0;
            lo    <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    case (op)
                        MDU_MULT, MDU_MULTU: {hi, lo} <= product;
                        MDU_MTHI:            hi <= SrcAE;
                        MDU_MTLO:            lo <= SrcAE;
                        MDU_DIV, MDU_DIVU: begin
                            q_neg <= a_neg ^ b_neg;
                            r_neg <= a_neg;
                            state <= ST_BUSY;
                        end
                        default: ;
                    endcase
                end
                ST_BUSY: begin
                    if (div_last)
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    // The div still on MDUOpE here is the finishing one; never restart.
                    lo    <= q_neg ? -quo : quo;
                    hi    <= r_neg ? -rem : rem;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        MDUReadyE = 1'b1;
        if (rst_n) begin
            case (state)
                ST_IDLE: MDUReadyE = !is_div;
                ST_BUSY: MDUReadyE = 1'b0;
                default: MDUReadyE = 1'b1;
            endcase
        end
    end

    always_comb begin
        MDUResultE = '0;
        case (op)
            MDU_MFHI: MDUResultE = hi;
            MDU_MFLO: MDUResultE = lo;
            default:  MDUResultE = '0;
        endcase
    end

endmodule
`default_nettype wire
